hdr_loader: RTL



---
 rtl/hdr_loader_if.sv | 29 ++
 rtl/hdr_loader.sv | 116 +++++++++++
 2 files changed

// File: rtl/hdr_loader_if.sv
// hdr_loader port bundle: inbound byte stream plus processor start/ready.
// master drives the stream and ready; slave is the loader itself.
interface hdr_loader_if #(
    parameter int HDR_MAX_LEN = 64,
    parameter int LEN_W       = 7
);
    logic                     in_valid_i;
    logic [7:0]               in_data_i;
    logic                     in_last_i;
    logic                     in_ready_o;
    logic [8*HDR_MAX_LEN-1:0] pkt_hdr_o;
    logic [LEN_W-1:0]         hdr_len_o;
    logic                     proc_start_o;
    logic                     proc_ready_i;
    logic                     done_o;
    logic [15:0]              trunc_cnt_o;

    modport master (
        output in_valid_i, in_data_i, in_last_i, proc_ready_i,
        input  in_ready_o, pkt_hdr_o, hdr_len_o, proc_start_o,
        input  done_o, trunc_cnt_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_last_i, proc_ready_i,
        output in_ready_o, pkt_hdr_o, hdr_len_o, proc_start_o,
        output done_o, trunc_cnt_o
    );
endinterface

// File: rtl/hdr_loader.sv
// Header loader: captures the first HDR_MAX_LEN bytes of a packet and
// hands the held buffer to the packet processor via start/ready.
module hdr_loader #(
    parameter int HDR_MAX_LEN = 64,
    parameter int LEN_W       = 7
) (
    input  logic         clk,
    input  logic         rst,
    hdr_loader_if.slave  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] ARM   = 3'd3;
    localparam logic [2:0] BUSY  = 3'd4;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(HDR_MAX_LEN);

    logic [2:0]                   state;
    logic [LEN_W-1:0]             cnt;
    logic [LEN_W-1:0]             cnt_inc;
    logic [LEN_W-1:0]             hdr_len;
    logic [HDR_MAX_LEN-1:0][7:0]  hdr;
    logic                         in_ready;
    logic                         proc_start;
    logic                         done;
    logic [15:0]                  trunc_cnt;
    logic                         acc;

    assign acc     = bus.in_valid_i && in_ready;
    assign cnt_inc = cnt + LEN_W'(1);

    assign bus.in_ready_o   = in_ready;
    assign bus.pkt_hdr_o    = hdr;
    assign bus.hdr_len_o    = hdr_len;
    assign bus.proc_start_o = proc_start;
    assign bus.done_o       = done;
    assign bus.trunc_cnt_o  = trunc_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hdr        <= '0;
            hdr_len    <= '0;
            in_ready   <= 1'b1;
            proc_start <= 1'b0;
            done       <= 1'b0;
            trunc_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc) begin
                        // Clear the whole buffer so no residue of the
                        // previous packet survives past its length.
                        for (int i = 0; i < HDR_MAX_LEN; i++)
                            hdr[i] <= (i == 0) ? bus.in_data_i : 8'h00;
                        cnt <= LEN_W'(1);
                        if (bus.in_last_i) begin
                            state    <= ARM;
                            hdr_len  <= LEN_W'(1);
                            in_ready <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (acc) begin
                        for (int i = 0; i < HDR_MAX_LEN; i++)
                            if (cnt == LEN_W'(i))
                                hdr[i] <= bus.in_data_i;
                        cnt <= cnt_inc;
                        if (bus.in_last_i) begin
                            state    <= ARM;
                            hdr_len  <= cnt_inc;
                            in_ready <= 1'b0;
                        end else if (cnt_inc == MAX_LEN) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (acc && bus.in_last_i) begin
                        if (trunc_cnt != 16'hFFFF)
                            trunc_cnt <= trunc_cnt + 16'd1;
                        state    <= ARM;
                        hdr_len  <= MAX_LEN;
                        in_ready <= 1'b0;
                    end
                end
                ARM: begin
                    // Wait out the processor's ready level left from the
                    // previous packet before looking for its completion.
                    proc_start <= 1'b1;
                    if (!bus.proc_ready_i)
                        state <= BUSY;
                end
                BUSY: begin
                    if (bus.proc_ready_i) begin
                        proc_start <= 1'b0;
                        done       <= 1'b1;
                        in_ready   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready   <= 1'b1;
                    proc_start <= 1'b0;
                end
            endcase
        end
    end
endmodule
